riscv_dmem_responder: RTL and testbench

- Data-memory responder on the far side of the CPU's data-memory interface.
- Accepts word-aligned load/store requests that already carry lane-shifted write data and byte selects.
- Performs byte-lane-masked writes or full-word reads on an internal word-organised RAM, with a programmable number of wait states.
- Reports completion with a one-cycle acknowledge.
- Returns the raw, unshifted word; sign/zero extension and lane alignment stay on the CPU side.

---
 rtl/riscv_dmem_responder.sv | 158 +++++++++++++++
 tb/tb_riscv_dmem_responder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_dmem_responder.sv
// Data-memory responder: accepts one word-aligned load/store request at a
// time, waits a fixed number of cycles, performs a byte-masked write or a
// full-word read on an internal RAM and signals completion with a one-cycle
// acknowledge. Addresses outside the RAM window complete with an error flag.
module riscv_dmem_responder #(
  parameter int              XLEN        = 32,
  parameter int              DEPTH_LOG2  = 10,
  parameter int              WAIT_CYCLES = 1,
  parameter logic [XLEN-1:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_dmem_req,
  input  logic                i_dmem_wr_en,
  input  logic [XLEN-1:0]     i_dmem_addr,
  input  logic [XLEN-1:0]     i_dmem_wr_data,
  input  logic [XLEN/8-1:0]   i_dmem_byte_sel,
  output logic [XLEN-1:0]     o_dmem_rd_data,
  output logic                o_dmem_ack,
  output logic                o_dmem_err,
  output logic                o_dmem_busy
);

  localparam int         SEL_W     = XLEN / 8;
  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Request captured at acceptance; the access uses only these afterwards.
  logic [3:0]       wait_cnt;
  logic             lat_wr_en;
  logic [XLEN-1:0]  lat_addr;
  logic [XLEN-1:0]  lat_wr_data;
  logic [SEL_W-1:0] lat_byte_sel;

  logic             err_q;
  logic [XLEN-1:0]  rd_data_q;

  logic [XLEN-1:0]  mem [DEPTH];

  logic             accept;
  logic             access;
  logic             acc_wr_en;
  logic [XLEN-1:0]  acc_addr;
  logic [XLEN-1:0]  acc_wr_data;
  logic [SEL_W-1:0] acc_byte_sel;
  logic [XLEN:0]    acc_offset;
  logic             acc_in_range;
  logic [DEPTH_LOG2-1:0] acc_index;
  logic             unused_low_bits;

  assign accept = (state == S_IDLE) && i_dmem_req;
  // The access happens on the edge that enters RESP.
  assign access = (state_nxt == S_RESP) && (state != S_RESP);

  // With zero wait states the access edge is also the accepting edge, so the
  // request is taken straight from the inputs; otherwise from the latches.
  assign acc_wr_en    = (state == S_IDLE) ? i_dmem_wr_en    : lat_wr_en;
  assign acc_addr     = (state == S_IDLE) ? i_dmem_addr     : lat_addr;
  assign acc_wr_data  = (state == S_IDLE) ? i_dmem_wr_data  : lat_wr_data;
  assign acc_byte_sel = (state == S_IDLE) ? i_dmem_byte_sel : lat_byte_sel;

  // Extra top bit of the subtraction is the borrow: set when addr < BASE_ADDR.
  assign acc_offset      = {1'b0, acc_addr} - {1'b0, BASE_ADDR};
  assign acc_in_range    = (acc_offset[XLEN:DEPTH_LOG2+2] == '0);
  assign acc_index       = acc_offset[DEPTH_LOG2+1:2];
  assign unused_low_bits = ^acc_offset[1:0];

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> (WAIT x WAIT_CYCLES) -> RESP -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (i_dmem_req) begin
          state_nxt = (WAIT_INIT == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt <= 4'd1) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode: ack/err only in RESP; busy covers the accepting cycle too.
  always_comb begin
    o_dmem_ack  = (state == S_RESP);
    o_dmem_err  = (state == S_RESP) && err_q;
    o_dmem_busy = (state != S_IDLE) || (i_rstn && i_dmem_req);
  end

  assign o_dmem_rd_data = rd_data_q;

  // Request latches and wait-state counter.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wait_cnt     <= 4'd0;
      lat_wr_en    <= 1'b0;
      lat_addr     <= '0;
      lat_wr_data  <= '0;
      lat_byte_sel <= '0;
    end else if (accept) begin
      wait_cnt     <= WAIT_INIT;
      lat_wr_en    <= i_dmem_wr_en;
      lat_addr     <= i_dmem_addr;
      lat_wr_data  <= i_dmem_wr_data;
      lat_byte_sel <= i_dmem_byte_sel;
    end else if ((state == S_WAIT) && (wait_cnt != 4'd0)) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Response registers: error flag for this access, load data held until
  // the next load completes.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      err_q     <= 1'b0;
      rd_data_q <= '0;
    end else if (access) begin
      err_q <= !acc_in_range;
      if (!acc_wr_en) begin
        rd_data_q <= acc_in_range ? mem[acc_index] : '0;
      end
    end
  end

  // RAM write port: byte-lane masked, never cleared, suppressed under reset.
  always_ff @(posedge i_clk) begin
    if (i_rstn && access && acc_wr_en && acc_in_range) begin
      for (int k = 0; k < SEL_W; k++) begin
        if (acc_byte_sel[k]) begin
          mem[acc_index][8*k +: 8] <= acc_wr_data[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Bench for riscv_dmem_responder: three instances (1, 0 and 3 wait states)
// driven with directed scenarios and random traffic against a word-array model.
module tb_riscv_dmem_responder;

  localparam logic [31:0] TB_BASE = 32'h0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn  [3];
  logic        req   [3];
  logic        wr_en [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  sel   [3];
  logic [31:0] rdata [3];
  logic        ack   [3];
  logic        err   [3];
  logic        busy  [3];

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl     [3][1024];
  bit          known   [3][1024];
  logic [31:0] last_rd [3];

  riscv_dmem_responder #(.XLEN(32), .DEPTH_LOG2(10), .WAIT_CYCLES(1), .BASE_ADDR(TB_BASE)) u_w1 (
    .i_clk(clk), .i_rstn(rstn[0]), .i_dmem_req(req[0]), .i_dmem_wr_en(wr_en[0]),
    .i_dmem_addr(addr[0]), .i_dmem_wr_data(wdata[0]), .i_dmem_byte_sel(sel[0]),
    .o_dmem_rd_data(rdata[0]), .o_dmem_ack(ack[0]), .o_dmem_err(err[0]), .o_dmem_busy(busy[0]));

  riscv_dmem_responder #(.XLEN(32), .DEPTH_LOG2(10), .WAIT_CYCLES(0), .BASE_ADDR(TB_BASE)) u_w0 (
    .i_clk(clk), .i_rstn(rstn[1]), .i_dmem_req(req[1]), .i_dmem_wr_en(wr_en[1]),
    .i_dmem_addr(addr[1]), .i_dmem_wr_data(wdata[1]), .i_dmem_byte_sel(sel[1]),
    .o_dmem_rd_data(rdata[1]), .o_dmem_ack(ack[1]), .o_dmem_err(err[1]), .o_dmem_busy(busy[1]));

  riscv_dmem_responder #(.XLEN(32), .DEPTH_LOG2(10), .WAIT_CYCLES(3), .BASE_ADDR(TB_BASE)) u_w3 (
    .i_clk(clk), .i_rstn(rstn[2]), .i_dmem_req(req[2]), .i_dmem_wr_en(wr_en[2]),
    .i_dmem_addr(addr[2]), .i_dmem_wr_data(wdata[2]), .i_dmem_byte_sel(sel[2]),
    .o_dmem_rd_data(rdata[2]), .o_dmem_ack(ack[2]), .o_dmem_err(err[2]), .o_dmem_busy(busy[2]));

  function automatic int wc(input int u);
    return (u == 0) ? 1 : ((u == 1) ? 0 : 3);
  endfunction

  // Reference model: word array, range rule and lane merge from plain arithmetic.
  task automatic model_apply(input int u, input bit w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [31:0] erd, output bit eerr);
    longint off;
    int     idx;
    bit     inr;
    off = longint'(a) - longint'(TB_BASE);
    inr = (off >= 0) && ((off / 4) < 1024);
    idx = inr ? int'(off / 4) : 0;
    if (!inr) begin
      eerr = 1'b1;
      if (!w) last_rd[u] = 32'h0;
    end else begin
      eerr = 1'b0;
      if (w) begin
        for (int k = 0; k < 4; k++)
          if (s[k]) mdl[u][idx][8*k +: 8] = d[8*k +: 8];
        if (s == 4'hF) known[u][idx] = 1'b1;
      end else begin
        last_rd[u] = mdl[u][idx];
      end
    end
    erd = last_rd[u];
  endtask

  // Issues one request and observes it until one cycle past its ack.
  task automatic txn(input int u, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd, output bit er, output int lat,
                     output int bsy, output bit stray, output bit ack_after);
    bit done;
    @(posedge clk); #1;
    req[u] = 1'b1; wr_en[u] = w; addr[u] = a; wdata[u] = d; sel[u] = s;
    #1;
    bsy = busy[u] ? 1 : 0;
    rd = 32'h0; er = 1'b0; lat = -1; stray = 1'b0; done = 1'b0; ack_after = 1'b0;
    @(posedge clk); #1;
    req[u] = 1'b0; wr_en[u] = 1'($urandom); addr[u] = $urandom; wdata[u] = $urandom;
    sel[u] = 4'($urandom);
    #1;
    for (int n = 1; n <= 20 && !done; n++) begin
      if (busy[u]) bsy++;
      if (ack[u]) begin
        done = 1'b1; lat = n; rd = rdata[u]; er = err[u];
      end else if (err[u]) begin
        stray = 1'b1;
      end
      @(posedge clk); #2;
    end
    if (busy[u]) bsy++;
    ack_after = ack[u];
  endtask

  task automatic test_reset();
    for (int u = 0; u < 3; u++) begin
      rstn[u] = 1'b0; req[u] = 1'b0; wr_en[u] = 1'b0; addr[u] = 32'h0;
      wdata[u] = 32'h0; sel[u] = 4'h0; last_rd[u] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      checks++; if (ack[u] !== 1'b0) begin errors++; $display("FAIL reset_ack u%0d: got %b expected 0", u, ack[u]); end
      checks++; if (err[u] !== 1'b0) begin errors++; $display("FAIL reset_err u%0d: got %b expected 0", u, err[u]); end
      checks++; if (busy[u] !== 1'b0) begin errors++; $display("FAIL reset_busy u%0d: got %b expected 0", u, busy[u]); end
      checks++; if (rdata[u] !== 32'h0) begin errors++; $display("FAIL reset_rdata u%0d: got %h expected 0", u, rdata[u]); end
    end
    @(negedge clk);
    for (int u = 0; u < 3; u++) rstn[u] = 1'b1;
  endtask

  task automatic test_store_load();
    logic [31:0] rd, erd; bit er, eerr, stray, aa; int lat, bsy;
    model_apply(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, erd, eerr);
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat, bsy, stray, aa);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sl_store_lat: got %0d expected 2", lat); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL sl_store_err: got %b expected 0", er); end
    checks++; if (bsy !== 3) begin errors++; $display("FAIL sl_store_busy: got %0d expected 3", bsy); end
    model_apply(0, 1'b0, 32'h10, 32'h0, 4'h0, erd, eerr);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, bsy, stray, aa);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sl_load_lat: got %0d expected 2", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL sl_load_data: got %h expected deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL sl_load_err: got %b expected 0", er); end
    checks++; if (aa !== 1'b0) begin errors++; $display("FAIL sl_ack_width: got %b expected 0", aa); end
  endtask

  task automatic test_byte_merge();
    logic [31:0] rd, erd; bit er, eerr, stray, aa; int lat, bsy;
    model_apply(0, 1'b1, 32'h12, 32'h00AB0000, 4'b0100, erd, eerr);
    txn(0, 1'b1, 32'h12, 32'h00AB0000, 4'b0100, rd, er, lat, bsy, stray, aa);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL bm_store_hold: got %h expected deadbeef", rd); end
    model_apply(0, 1'b0, 32'h10, 32'h0, 4'h0, erd, eerr);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, bsy, stray, aa);
    checks++; if (rd !== 32'hDEABBEEF) begin errors++; $display("FAIL bm_merge: got %h expected deabbeef", rd); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd, erd; bit er, eerr, stray, aa; int lat, bsy;
    model_apply(0, 1'b1, 32'h0, 32'h01020304, 4'hF, erd, eerr);
    txn(0, 1'b1, 32'h0, 32'h01020304, 4'hF, rd, er, lat, bsy, stray, aa);
    model_apply(0, 1'b0, 32'h1000, 32'h0, 4'h0, erd, eerr);
    txn(0, 1'b0, 32'h1000, 32'h0, 4'h0, rd, er, lat, bsy, stray, aa);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_load_err: got %b expected 1", er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_load_data: got %h expected 0", rd); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL oor_load_lat: got %0d expected 2", lat); end
    checks++; if (stray !== 1'b0) begin errors++; $display("FAIL oor_err_without_ack: got %b expected 0", stray); end
    model_apply(0, 1'b1, 32'h1000, 32'h12345678, 4'hF, erd, eerr);
    txn(0, 1'b1, 32'h1000, 32'h12345678, 4'hF, rd, er, lat, bsy, stray, aa);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_store_err: got %b expected 1", er); end
    model_apply(0, 1'b0, 32'h0, 32'h0, 4'h0, erd, eerr);
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat, bsy, stray, aa);
    checks++; if (rd !== 32'h01020304) begin errors++; $display("FAIL oor_word0: got %h expected 01020304", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL oor_word0_err: got %b expected 0", er); end
  endtask

  task automatic test_busy_hold();
    logic [31:0] rd, erd, r1, r2; bit er, eerr, stray, aa; int lat, bsy;
    int nack, t1, t2;
    model_apply(0, 1'b1, 32'h40, 32'hAAAA0001, 4'hF, erd, eerr);
    txn(0, 1'b1, 32'h40, 32'hAAAA0001, 4'hF, rd, er, lat, bsy, stray, aa);
    model_apply(0, 1'b1, 32'h44, 32'hBBBB0002, 4'hF, erd, eerr);
    txn(0, 1'b1, 32'h44, 32'hBBBB0002, 4'hF, rd, er, lat, bsy, stray, aa);
    model_apply(0, 1'b1, 32'h48, 32'hCCCC0003, 4'hF, erd, eerr);
    txn(0, 1'b1, 32'h48, 32'hCCCC0003, 4'hF, rd, er, lat, bsy, stray, aa);
    model_apply(0, 1'b1, 32'h4C, 32'hDDDD0004, 4'hF, erd, eerr);
    txn(0, 1'b1, 32'h4C, 32'hDDDD0004, 4'hF, rd, er, lat, bsy, stray, aa);
    nack = 0; t1 = -1; t2 = -1; r1 = 32'h0; r2 = 32'h0;
    @(posedge clk); #1;
    req[0] = 1'b1; wr_en[0] = 1'b0; addr[0] = 32'h40; sel[0] = 4'hF;
    for (int t = 1; t <= 12; t++) begin
      @(posedge clk); #1;
      if (ack[0]) begin
        nack++;
        if (nack == 1) begin t1 = t; r1 = rdata[0]; addr[0] = 32'h44; end
        else if (nack == 2) begin t2 = t; r2 = rdata[0]; req[0] = 1'b0; end
      end else if (req[0] && t != t1 + 1) begin
        addr[0] = (t % 2 == 1) ? 32'h48 : 32'h4C;
      end
    end
    last_rd[0] = mdl[0][17];
    checks++; if (t1 !== 2) begin errors++; $display("FAIL bh_first_ack: got %0d expected 2", t1); end
    checks++; if ((t2 - t1) !== 3) begin errors++; $display("FAIL bh_ack_spacing: got %0d expected 3", t2 - t1); end
    checks++; if (r1 !== mdl[0][16]) begin errors++; $display("FAIL bh_first_data: got %h expected %h", r1, mdl[0][16]); end
    checks++; if (r2 !== mdl[0][17]) begin errors++; $display("FAIL bh_second_data: got %h expected %h", r2, mdl[0][17]); end
    checks++; if (nack !== 2) begin errors++; $display("FAIL bh_ack_count: got %0d expected 2", nack); end
  endtask

  task automatic test_wait_cfg();
    logic [31:0] rd, erd, d; bit er, eerr, stray, aa; int lat, bsy;
    for (int u = 1; u < 3; u++) begin
      d = $urandom;
      model_apply(u, 1'b1, 32'h8, d, 4'hF, erd, eerr);
      txn(u, 1'b1, 32'h8, d, 4'hF, rd, er, lat, bsy, stray, aa);
      model_apply(u, 1'b0, 32'h8, 32'h0, 4'h0, erd, eerr);
      txn(u, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat, bsy, stray, aa);
      checks++; if (lat !== wc(u) + 1) begin errors++; $display("FAIL wc_lat u%0d: got %0d expected %0d", u, lat, wc(u) + 1); end
      checks++; if (bsy !== wc(u) + 2) begin errors++; $display("FAIL wc_busy u%0d: got %0d expected %0d", u, bsy, wc(u) + 2); end
      checks++; if (rd !== erd) begin errors++; $display("FAIL wc_data u%0d: got %h expected %h", u, rd, erd); end
    end
  endtask

  task automatic test_reset_mid_store();
    logic [31:0] rd, erd; bit er, eerr, stray, aa; int lat, bsy, nack;
    model_apply(0, 1'b1, 32'h20, 32'h11112222, 4'hF, erd, eerr);
    txn(0, 1'b1, 32'h20, 32'h11112222, 4'hF, rd, er, lat, bsy, stray, aa);
    model_apply(0, 1'b0, 32'h10, 32'h0, 4'h0, erd, eerr);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, bsy, stray, aa);
    @(posedge clk); #1;
    req[0] = 1'b1; wr_en[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'hCAFEF00D; sel[0] = 4'hF;
    @(posedge clk); #1;
    req[0] = 1'b0;
    rstn[0] = 1'b0;
    #1;
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b expected 0", busy[0]); end
    checks++; if (ack[0] !== 1'b0) begin errors++; $display("FAIL rm_ack: got %b expected 0", ack[0]); end
    checks++; if (rdata[0] !== 32'h0) begin errors++; $display("FAIL rm_rdata: got %h expected 0", rdata[0]); end
    nack = 0;
    repeat (2) begin @(posedge clk); #1; if (ack[0]) nack++; end
    @(negedge clk);
    rstn[0] = 1'b1;
    repeat (4) begin @(posedge clk); #1; if (ack[0]) nack++; end
    checks++; if (nack !== 0) begin errors++; $display("FAIL rm_dropped_ack: got %0d expected 0", nack); end
    last_rd[0] = 32'h0;
    model_apply(0, 1'b0, 32'h20, 32'h0, 4'h0, erd, eerr);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, bsy, stray, aa);
    checks++; if (rd !== 32'h11112222) begin errors++; $display("FAIL rm_retained: got %h expected 11112222", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, a, d; logic [3:0] s; bit er, eerr, stray, aa, w, oor; int lat, bsy, widx;
    for (int u = 0; u < 3; u++) begin
      for (int i = 0; i < 40; i++) begin
        widx = $urandom_range(0, 15);
        oor  = ($urandom_range(0, 7) == 0);
        a    = oor ? (32'h0000_1000 | $urandom) : (32'(widx) * 4 + 32'($urandom_range(0, 3)));
        w    = (oor || known[u][widx]) ? 1'($urandom) : 1'b1;
        s    = (w && !oor && !known[u][widx]) ? 4'hF : 4'($urandom);
        d    = $urandom;
        model_apply(u, w, a, d, s, erd, eerr);
        txn(u, w, a, d, s, rd, er, lat, bsy, stray, aa);
        checks++; if (lat !== wc(u) + 1) begin errors++; $display("FAIL rnd_lat u%0d i%0d: got %0d expected %0d", u, i, lat, wc(u) + 1); end
        checks++; if (er !== eerr) begin errors++; $display("FAIL rnd_err u%0d i%0d a=%h: got %b expected %b", u, i, a, er, eerr); end
        checks++; if (rd !== erd) begin errors++; $display("FAIL rnd_data u%0d i%0d a=%h w=%b: got %h expected %h", u, i, a, w, rd, erd); end
        checks++; if (bsy !== wc(u) + 2) begin errors++; $display("FAIL rnd_busy u%0d i%0d: got %0d expected %0d", u, i, bsy, wc(u) + 2); end
        checks++; if ({stray, aa} !== 2'b00) begin errors++; $display("FAIL rnd_stray u%0d i%0d: got %b expected 00", u, i, {stray, aa}); end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_load();
    test_byte_merge();
    test_out_of_range();
    test_busy_hold();
    test_wait_cfg();
    test_reset_mid_store();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
